mem_burst_v3: RTL and testbench

Parametrised burst adapter between the frame-buffer read/write masters and the DDR2 controller local interface. Long user bursts (1 to 2^LEN_BITS−1 words) are split into local bursts of up to BURST_SIZE beats, with short tail bursts sized exactly. When read and write requests are both pending, the block alternates priority between them. A stalled read triggers a timed controller reset. Drop-in successor for frame-buffer users; user-side port semantics are unchanged except for the added error pulse.

---
 rtl/mem_burst_v3.sv | 199 +++++++++++++++++++
 tb/tb_mem_burst_v3.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_v3.sv
// Burst adapter between frame-buffer masters and the DDR2 local interface: splits
// user bursts into local bursts, alternates read/write priority, recovers stalled reads.
module mem_burst_v3 #(
    parameter int MEM_DATA_BITS   = 32,
    parameter int ADDR_BITS       = 24,
    parameter int LOCAL_SIZE_BITS = 3,
    parameter int BURST_SIZE      = 2,
    parameter int LEN_BITS        = 10,
    parameter int RD_TIMEOUT      = 200,
    parameter int RST_PULSE       = 4
) (
    input  logic                         mem_clk,
    input  logic                         rst_n,
    input  logic                         rd_burst_req,
    input  logic                         wr_burst_req,
    input  logic [LEN_BITS-1:0]          rd_burst_len,
    input  logic [LEN_BITS-1:0]          wr_burst_len,
    input  logic [ADDR_BITS-1:0]         rd_burst_addr,
    input  logic [ADDR_BITS-1:0]         wr_burst_addr,
    output logic                         rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0]     rd_burst_data,
    output logic                         wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0]     wr_burst_data,
    output logic                         rd_burst_finish,
    output logic                         wr_burst_finish,
    output logic                         burst_finish,
    output logic                         rd_timeout_err,
    input  logic                         local_init_done,
    input  logic                         local_ready,
    input  logic                         local_rdata_valid,
    input  logic [MEM_DATA_BITS-1:0]     local_rdata,
    output logic                         local_burstbegin,
    output logic                         local_read_req,
    output logic                         local_write_req,
    output logic [ADDR_BITS-1:0]         local_address,
    output logic [LOCAL_SIZE_BITS-1:0]   local_size,
    output logic [MEM_DATA_BITS-1:0]     local_wdata,
    output logic [MEM_DATA_BITS/8-1:0]   local_be,
    output logic                         ddr_rst_n
);
    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);
    localparam int RST_W = $clog2(RST_PULSE + 1);
    localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

    typedef enum logic [2:0] {
        IDLE, RD_CMD, RD_WAIT, WR_FIRST, WR_BEGIN, WR_DATA, RECOVER
    } state_t;

    state_t                     state_q;
    logic [ADDR_BITS-1:0]       addr_q;
    logic [LOCAL_SIZE_BITS-1:0] size_q;
    logic [LEN_BITS-1:0]        len_q, rem_q, rd_cnt_q, beat_q;
    logic [TMR_W-1:0]           timer_q;
    logic [RST_W-1:0]           rst_cnt_q;
    logic                       last_wr_q, err_q, ddr_rst_n_q;

    logic                in_rd, in_wr, accept, rd_beat, rd_last, wr_last;
    logic                rd_pend, wr_pend, rd_grant, wr_grant;
    logic [LEN_BITS-1:0] size_ext, rem_d;

    function automatic logic [LOCAL_SIZE_BITS-1:0] burst_min(input logic [LEN_BITS-1:0] n);
        if (n > LEN_BITS'(BURST_SIZE))
            return LOCAL_SIZE_BITS'(BURST_SIZE);
        return LOCAL_SIZE_BITS'(n);
    endfunction

    assign in_rd    = (state_q == RD_CMD) || (state_q == RD_WAIT);
    assign in_wr    = (state_q == WR_BEGIN) || (state_q == WR_DATA);
    assign accept   = in_wr && local_ready && local_init_done;
    assign rd_beat  = in_rd && local_rdata_valid && local_init_done;
    assign rd_last  = rd_beat && (state_q == RD_WAIT) && (rd_cnt_q + ONE == len_q);
    assign wr_last  = accept && (rem_q == ONE);
    assign size_ext = LEN_BITS'(size_q);
    assign rem_d    = rem_q - size_ext;

    // A zero-length request is never granted; on a tie the type not served last wins.
    assign rd_pend  = rd_burst_req && (rd_burst_len != '0);
    assign wr_pend  = wr_burst_req && (wr_burst_len != '0);
    assign rd_grant = rd_pend && (!wr_pend || last_wr_q);
    assign wr_grant = wr_pend && !rd_grant;

    // Counting requests while the remaining count (this beat included) is >= 2,
    // plus the prefetch in WR_FIRST, yields exactly len requests.
    assign wr_burst_data_req   = ((state_q == WR_FIRST) && local_init_done)
                               || (accept && (rem_q >= LEN_BITS'(2)));
    assign rd_burst_data_valid = rd_beat;
    assign rd_burst_data       = local_rdata;
    assign rd_burst_finish     = (rd_last || err_q) && local_init_done;
    assign wr_burst_finish     = wr_last;
    assign burst_finish        = rd_burst_finish || wr_burst_finish;
    assign rd_timeout_err      = err_q;
    assign local_read_req      = (state_q == RD_CMD);
    assign local_write_req     = in_wr;
    assign local_burstbegin    = (state_q == RD_CMD) || (state_q == WR_BEGIN);
    assign local_address       = addr_q;
    assign local_size          = size_q;
    assign local_wdata         = wr_burst_data;
    assign local_be            = '1;
    assign ddr_rst_n           = ddr_rst_n_q;

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            rd_cnt_q    <= '0;
            beat_q      <= '0;
            timer_q     <= '0;
            rst_cnt_q   <= '0;
            last_wr_q   <= 1'b1;
            err_q       <= 1'b0;
            ddr_rst_n_q <= 1'b1;
        end else if (!local_init_done) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            rst_cnt_q   <= '0;
            err_q       <= 1'b0;
            ddr_rst_n_q <= 1'b1;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rd_cnt_q <= '0;
                    beat_q   <= '0;
                    timer_q  <= '0;
                    if (rd_grant) begin
                        state_q   <= RD_CMD;
                        addr_q    <= rd_burst_addr;
                        len_q     <= rd_burst_len;
                        rem_q     <= rd_burst_len;
                        size_q    <= burst_min(rd_burst_len);
                        last_wr_q <= 1'b0;
                    end else if (wr_grant) begin
                        state_q   <= WR_FIRST;
                        addr_q    <= wr_burst_addr;
                        len_q     <= wr_burst_len;
                        rem_q     <= wr_burst_len;
                        size_q    <= burst_min(wr_burst_len);
                        last_wr_q <= 1'b1;
                    end
                end
                RD_CMD: begin
                    if (rd_beat)
                        rd_cnt_q <= rd_cnt_q + ONE;
                    if (local_ready) begin
                        addr_q <= addr_q + ADDR_BITS'(size_q);
                        rem_q  <= rem_d;
                        size_q <= burst_min(rem_d);
                        if (rem_d == '0)
                            state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_beat) begin
                        rd_cnt_q <= rd_cnt_q + ONE;
                        timer_q  <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                    if (rd_last) begin
                        state_q <= IDLE;
                    end else if (!rd_beat && (timer_q == TMR_W'(RD_TIMEOUT))) begin
                        state_q     <= RECOVER;
                        err_q       <= 1'b1;
                        ddr_rst_n_q <= 1'b0;
                        rst_cnt_q   <= '0;
                    end
                end
                WR_FIRST: state_q <= WR_BEGIN;
                WR_BEGIN, WR_DATA: begin
                    if (local_ready) begin
                        rem_q <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_q <= IDLE;
                        end else if (beat_q + ONE == size_ext) begin
                            addr_q  <= addr_q + ADDR_BITS'(size_q);
                            size_q  <= burst_min(rem_q - ONE);
                            beat_q  <= '0;
                            state_q <= WR_BEGIN;
                        end else begin
                            beat_q  <= beat_q + ONE;
                            state_q <= WR_DATA;
                        end
                    end
                end
                RECOVER: begin
                    rst_cnt_q <= rst_cnt_q + RST_W'(1);
                    if (rst_cnt_q == RST_W'(RST_PULSE - 1)) begin
                        ddr_rst_n_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_burst_v3.sv
// Scoreboard bench for mem_burst_v3 with a small DDR controller responder.
module tb_mem_burst_v3;
    localparam int DW = 32;
    localparam int AW = 24;
    localparam int SW = 3;
    localparam int LW = 10;

    logic          mem_clk, rst_n;
    logic          rd_burst_req, wr_burst_req;
    logic [LW-1:0] rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          wr_burst_data_req;
    logic [DW-1:0] wr_burst_data;
    logic          rd_burst_finish, wr_burst_finish, burst_finish, rd_timeout_err;
    logic          local_init_done, local_ready, local_rdata_valid;
    logic [DW-1:0] local_rdata;
    logic          local_burstbegin, local_read_req, local_write_req;
    logic [AW-1:0] local_address;
    logic [SW-1:0] local_size;
    logic [DW-1:0] local_wdata;
    logic [DW/8-1:0] local_be;
    logic          ddr_rst_n;

    mem_burst_v3 #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .LOCAL_SIZE_BITS(SW), .BURST_SIZE(2),
                   .LEN_BITS(LW), .RD_TIMEOUT(200), .RST_PULSE(4)) dut (
        .mem_clk(mem_clk), .rst_n(rst_n),
        .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req),
        .rd_burst_len(rd_burst_len), .wr_burst_len(wr_burst_len),
        .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
        .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
        .burst_finish(burst_finish), .rd_timeout_err(rd_timeout_err),
        .local_init_done(local_init_done), .local_ready(local_ready),
        .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata),
        .local_burstbegin(local_burstbegin), .local_read_req(local_read_req),
        .local_write_req(local_write_req), .local_address(local_address),
        .local_size(local_size), .local_wdata(local_wdata), .local_be(local_be),
        .ddr_rst_n(ddr_rst_n)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int n_pass = 0;
    int n_chk  = 0;

    logic [26:0] exp_rcmd[$];   // {addr, size}
    logic [59:0] exp_wbeat[$];  // {burstbegin, addr, size, data}
    logic [31:0] exp_rdata[$];
    logic [2:0]  exp_evt[$];    // {rd_finish, wr_finish, timeout_err}

    logic [AW-1:0] rd_pend[$];
    int            beats_left = 1000;
    int            wr_word = 0;
    logic [DW-1:0] wbase = '0;
    int            wreq_cnt = 0;
    logic          env_wreq;

    localparam logic [2:0] EV_R = 3'b100, EV_W = 3'b010, EV_E = 3'b101;

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a);
        return {8'hD0, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got %h, expected nothing", name, act);
    endtask

    task automatic push_wb(input logic bb, input logic [AW-1:0] a, input logic [SW-1:0] s,
                           input logic [DW-1:0] d);
        exp_wbeat.push_back({bb, a, s, d});
    endtask

    // Monitor: pops expectations whenever the DUT presents an observable transaction.
    initial begin
        forever begin
            @(negedge mem_clk);
            if (rst_n) begin
                if (local_read_req && local_ready && local_init_done) begin
                    if (exp_rcmd.size() == 0) unexpected("rd_cmd", {local_address, local_size});
                    else check("rd_cmd", {local_burstbegin, local_address, local_size},
                               {1'b1, exp_rcmd.pop_front()});
                end
                if (local_write_req && local_ready && local_init_done) begin
                    if (exp_wbeat.size() == 0) unexpected("wr_beat", {local_address, local_wdata});
                    else check("wr_beat", {local_burstbegin, local_address, local_size, local_wdata},
                               exp_wbeat.pop_front());
                end
                if (rd_burst_data_valid) begin
                    if (exp_rdata.size() == 0) unexpected("rd_data", rd_burst_data);
                    else check("rd_data", rd_burst_data, exp_rdata.pop_front());
                end
                if (rd_burst_finish || wr_burst_finish || rd_timeout_err || burst_finish) begin
                    logic [2:0] e;
                    if (exp_evt.size() == 0)
                        unexpected("finish", {rd_burst_finish, wr_burst_finish, rd_timeout_err});
                    else begin
                        e = exp_evt.pop_front();
                        check("finish", {rd_burst_finish, wr_burst_finish, rd_timeout_err, burst_finish},
                              {e, e[2] | e[1]});
                    end
                end
            end
        end
    end

    // Controller read responder and user write-data source.
    initial begin
        forever begin
            @(negedge mem_clk);
            env_wreq = wr_burst_data_req;
            if (wr_burst_data_req) wreq_cnt++;
            if (local_read_req && local_ready && local_init_done)
                for (int i = 0; i < int'(local_size); i++) rd_pend.push_back(local_address + AW'(i));
            @(posedge mem_clk);
            #1;
            if (env_wreq) begin
                wr_burst_data = wbase + 32'(wr_word);
                wr_word++;
            end
            if (rd_pend.size() > 0 && beats_left > 0) begin
                local_rdata       = rd_word(rd_pend.pop_front());
                local_rdata_valid = 1'b1;
                beats_left--;
            end else begin
                local_rdata_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge mem_clk);
        #2;
    endtask

    function automatic logic probe(input int which);
        case (which)
            0:       return rd_burst_finish;
            1:       return wr_burst_finish;
            default: return local_write_req && local_ready && local_init_done;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge mem_clk);
            if (probe(which)) begin
                seen = 1'b1;
                break;
            end
        end
        n_chk++;
        if (seen) n_pass++;
        else $display("FAIL %s: got no event, expected one within 600 cycles", name);
    endtask

    task automatic check_reset(input string name);
        check(name, {rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish,
                     burst_finish, rd_timeout_err, local_burstbegin, local_read_req,
                     local_write_req, local_address, local_size, ddr_rst_n, local_be},
              {9'b0, 24'h0, 3'h0, 1'b1, 4'hF});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1);
    end

    initial begin
        int busy, low;
        logic first;
        rst_n = 1'b0; rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        rd_burst_len = '0; wr_burst_len = '0; rd_burst_addr = '0; wr_burst_addr = '0;
        wr_burst_data = '0; local_init_done = 1'b1; local_ready = 1'b1;
        local_rdata_valid = 1'b0; local_rdata = '0;
        #12;
        check_reset("reset_values");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Zero-length request is ignored.
        rd_burst_req = 1'b1; rd_burst_len = '0; rd_burst_addr = 24'h000050;
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge mem_clk);
            if (local_read_req || local_write_req) busy++;
        end
        check("len0_ignored", 64'(busy), 64'd0);
        tick();
        rd_burst_req = 1'b0;

        // Read len=5 at 0x100: local bursts 2,2,1.
        exp_rcmd.push_back({24'h000100, 3'd2});
        exp_rcmd.push_back({24'h000102, 3'd2});
        exp_rcmd.push_back({24'h000104, 3'd1});
        for (int i = 0; i < 5; i++) exp_rdata.push_back(rd_word(24'h000100 + AW'(i)));
        exp_evt.push_back(EV_R);
        tick();
        rd_burst_req = 1'b1; rd_burst_len = 10'd5; rd_burst_addr = 24'h000100;
        wait_for(0, "rd5_finish");
        tick();
        rd_burst_req = 1'b0;

        // Write len=3 at 0x40 with two stall cycles after the first beat.
        push_wb(1'b1, 24'h000040, 3'd2, 32'd0);
        push_wb(1'b0, 24'h000040, 3'd2, 32'd1);
        push_wb(1'b1, 24'h000042, 3'd1, 32'd2);
        exp_evt.push_back(EV_W);
        tick();
        wbase = 32'd0; wr_word = 0; wreq_cnt = 0;
        wr_burst_req = 1'b1; wr_burst_len = 10'd3; wr_burst_addr = 24'h000040;
        wait_for(2, "wr3_first_beat");
        tick();
        local_ready = 1'b0;
        tick(); tick();
        local_ready = 1'b1;
        wait_for(1, "wr3_finish");
        tick();
        wr_burst_req = 1'b0;
        tick();
        check("wr3_data_req_count", 64'(wreq_cnt), 64'd3);

        // Simultaneous requests alternate: R(0x300), W(0x400), R(0x310), W(0x410).
        exp_rcmd.push_back({24'h000300, 3'd2});
        exp_rcmd.push_back({24'h000310, 3'd2});
        exp_rdata.push_back(rd_word(24'h000300)); exp_rdata.push_back(rd_word(24'h000301));
        exp_rdata.push_back(rd_word(24'h000310)); exp_rdata.push_back(rd_word(24'h000311));
        push_wb(1'b1, 24'h000400, 3'd2, 32'hA000_0000);
        push_wb(1'b0, 24'h000400, 3'd2, 32'hA000_0001);
        push_wb(1'b1, 24'h000410, 3'd2, 32'hB000_0000);
        push_wb(1'b0, 24'h000410, 3'd2, 32'hB000_0001);
        exp_evt.push_back(EV_R); exp_evt.push_back(EV_W);
        exp_evt.push_back(EV_R); exp_evt.push_back(EV_W);
        tick();
        wbase = 32'hA000_0000; wr_word = 0;
        rd_burst_req = 1'b1; rd_burst_len = 10'd2; rd_burst_addr = 24'h000300;
        wr_burst_req = 1'b1; wr_burst_len = 10'd2; wr_burst_addr = 24'h000400;
        wait_for(0, "arb_read1");
        tick();
        rd_burst_addr = 24'h000310;
        wait_for(1, "arb_write1");
        tick();
        wr_burst_addr = 24'h000410; wbase = 32'hB000_0000; wr_word = 0;
        wait_for(0, "arb_read2");
        tick();
        rd_burst_req = 1'b0;
        wait_for(1, "arb_write2");
        tick();
        wr_burst_req = 1'b0;

        // Address wrap: len=1 at 0xFFFFFF, then len=3 at 0xFFFFFE.
        push_wb(1'b1, 24'hFFFFFF, 3'd1, 32'hC000_0000);
        push_wb(1'b1, 24'hFFFFFE, 3'd2, 32'hD000_0000);
        push_wb(1'b0, 24'hFFFFFE, 3'd2, 32'hD000_0001);
        push_wb(1'b1, 24'h000000, 3'd1, 32'hD000_0002);
        exp_evt.push_back(EV_W); exp_evt.push_back(EV_W);
        tick();
        wbase = 32'hC000_0000; wr_word = 0;
        wr_burst_req = 1'b1; wr_burst_len = 10'd1; wr_burst_addr = 24'hFFFFFF;
        wait_for(1, "wrap_len1");
        tick();
        wbase = 32'hD000_0000; wr_word = 0;
        wr_burst_len = 10'd3; wr_burst_addr = 24'hFFFFFE;
        wait_for(1, "wrap_len3");
        tick();
        wr_burst_req = 1'b0;

        // Read timeout: only 2 of 4 beats come back.
        exp_rcmd.push_back({24'h000200, 3'd2});
        exp_rcmd.push_back({24'h000202, 3'd2});
        exp_rdata.push_back(rd_word(24'h000200)); exp_rdata.push_back(rd_word(24'h000201));
        exp_evt.push_back(EV_E);
        tick();
        beats_left = 2;
        rd_burst_req = 1'b1; rd_burst_len = 10'd4; rd_burst_addr = 24'h000200;
        wait_for(0, "timeout_finish");
        first = ddr_rst_n;
        tick();
        rd_burst_req = 1'b0;
        rd_pend.delete();
        beats_left = 1000;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge mem_clk);
            if (ddr_rst_n == 1'b0) low++;
            else break;
        end
        check("ddr_rst_n_low_cycles", 64'(low + (first ? 0 : 1)), 64'd4);
        @(negedge mem_clk);
        check("recover_to_idle", {local_read_req, local_write_req, ddr_rst_n}, 3'b001);

        // local_init_done drops mid-write: back to IDLE, no finish pulse.
        push_wb(1'b1, 24'h000500, 3'd2, 32'hE000_0000);
        tick();
        wbase = 32'hE000_0000; wr_word = 0;
        wr_burst_req = 1'b1; wr_burst_len = 10'd6; wr_burst_addr = 24'h000500;
        wait_for(2, "init_drop_first_beat");
        tick();
        local_ready = 1'b0;
        tick();
        local_init_done = 1'b0;
        @(negedge mem_clk);
        @(negedge mem_clk);
        check("init_drop_write_req", {local_write_req, wr_burst_finish, burst_finish}, 3'b000);
        tick();
        wr_burst_req = 1'b0; local_init_done = 1'b1; local_ready = 1'b1;
        tick(); tick();

        // Asynchronous reset in the middle of a read.
        exp_rcmd.push_back({24'h000600, 3'd2});
        exp_rcmd.push_back({24'h000602, 3'd2});
        beats_left = 0;
        rd_burst_req = 1'b1; rd_burst_len = 10'd4; rd_burst_addr = 24'h000600;
        for (int i = 0; i < 5; i++) @(posedge mem_clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset_mid_read");
        rd_burst_req = 1'b0;
        tick();
        rd_pend.delete();
        beats_left = 1000;
        rst_n = 1'b1;
        tick(); tick(); tick();

        check("left_rd_cmd", 64'(exp_rcmd.size()), 64'd0);
        check("left_wr_beat", 64'(exp_wbeat.size()), 64'd0);
        check("left_rd_data", 64'(exp_rdata.size()), 64'd0);
        check("left_finish", 64'(exp_evt.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
